// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the MIPS datapath hazard logic.
//   regbits_t       - 5-bit architectural register index
//   hazard_state_t  - hazard sequencer states
//   stage_ctl_t     - one bit per pipeline latch {fd, de, em, mwb}
//   src_match()     - true when a nonzero destination feeds rs or rt
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      HALTED     = 2'd3
   } hazard_state_t;

   localparam int MAX_LOAD_STALL = 3;

   typedef struct packed {
      logic fd;
      logic de;
      logic em;
      logic mwb;
   } stage_ctl_t;

   // r0 is hardwired to zero, so it can never carry a dependency.
   function automatic logic src_match(regbits_t rd, regbits_t rs, regbits_t rt);
      return (rd != 5'd0) && ((rd == rs) || (rd == rt));
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-field inputs and hu_* control outputs of the
// hazard unit.
//   master - pipeline side: drives latch fields, receives flush/enable
//   slave  - hazard unit side
interface hazard_unit_if #(
   parameter int CNT_W = 32
);
   import cpu_types_pkg::*;

   logic             ihit;
   logic             dhit;
   regbits_t         id_rs;
   regbits_t         id_rt;
   regbits_t         ex_rd;
   logic             ex_mem_to_reg;
   logic             ex_mem_wr;
   regbits_t         mem_rd;
   logic             mem_mem_to_reg;
   logic             mem_dren;
   logic             mem_dwen;
   logic             mem_branch_taken;
   logic             id_jump;
   logic             mem_halt;

   logic             hu_fetch_decode_flush;
   logic             hu_fetch_decode_enable;
   logic             hu_decode_execute_flush;
   logic             hu_decode_execute_enable;
   logic             hu_execute_memory_flush;
   logic             hu_execute_memory_enable;
   logic             hu_memory_write_back_flush;
   logic             hu_memory_write_back_enable;
   logic             hu_decode_execute_conflict;
   logic             hu_decode_memory_conflict;
   logic             hu_is_mem;
   logic             halt;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output ihit, dhit, id_rs, id_rt, ex_rd, ex_mem_to_reg, ex_mem_wr,
             mem_rd, mem_mem_to_reg, mem_dren, mem_dwen, mem_branch_taken,
             id_jump, mem_halt,
      input  hu_fetch_decode_flush, hu_fetch_decode_enable,
             hu_decode_execute_flush, hu_decode_execute_enable,
             hu_execute_memory_flush, hu_execute_memory_enable,
             hu_memory_write_back_flush, hu_memory_write_back_enable,
             hu_decode_execute_conflict, hu_decode_memory_conflict,
             hu_is_mem, halt, stall_cycles
   );

   modport slave (
      input  ihit, dhit, id_rs, id_rt, ex_rd, ex_mem_to_reg, ex_mem_wr,
             mem_rd, mem_mem_to_reg, mem_dren, mem_dwen, mem_branch_taken,
             id_jump, mem_halt,
      output hu_fetch_decode_flush, hu_fetch_decode_enable,
             hu_decode_execute_flush, hu_decode_execute_enable,
             hu_execute_memory_flush, hu_execute_memory_enable,
             hu_memory_write_back_flush, hu_memory_write_back_enable,
             hu_decode_execute_conflict, hu_decode_memory_conflict,
             hu_is_mem, halt, stall_cycles
   );

endinterface

// File: rtl/hazard_detect_comb.sv
// hazard_detect_comb: register-dependency comparators for the decode stage.
//   id_rs_i, id_rt_i      - sources of the instruction in fetch/decode
//   ex_rd_i, ex_load_i    - destination / is-load of decode/execute
//   mem_rd_i, mem_load_i  - destination / is-load of execute/memory
//   ex_conflict_o         - load-use hazard against execute stage
//   mem_conflict_o        - load in memory stage feeds a decode source
module hazard_detect_comb
   import cpu_types_pkg::*;
(
   input  regbits_t id_rs_i,
   input  regbits_t id_rt_i,
   input  regbits_t ex_rd_i,
   input  logic     ex_load_i,
   input  regbits_t mem_rd_i,
   input  logic     mem_load_i,
   output logic     ex_conflict_o,
   output logic     mem_conflict_o
);

   assign ex_conflict_o  = ex_load_i  & src_match(ex_rd_i,  id_rs_i, id_rt_i);
   assign mem_conflict_o = mem_load_i & src_match(mem_rd_i, id_rs_i, id_rt_i);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush sequencer for one core of the MIPS pipeline.
//   CLK, RST - core clock, asynchronous active-high reset
//   hu       - slave side of hazard_unit_if (latch fields in, hu_* out)
// Priority of events: dcache wait, halt, taken branch, load-use, jump,
// icache miss. Flush/enable outputs are combinational from state + inputs.
module hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 32
) (
   input logic          CLK,
   input logic          RST,
   hazard_unit_if.slave hu
);

   // Bubbles still owed after the one inserted on detection.
   localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES - 1);

   hazard_state_t    state_q, state_d, eff_state;
   logic [1:0]       bcnt_q, bcnt_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] stall_q;

   logic             ex_conf, mem_conf, is_mem, wait_c;
   stage_ctl_t       flush, en;
   logic             unused_ex_mem_wr;

   assign unused_ex_mem_wr = hu.ex_mem_wr;

   hazard_detect_comb u_detect (
      .id_rs_i        (hu.id_rs),
      .id_rt_i        (hu.id_rt),
      .ex_rd_i        (hu.ex_rd),
      .ex_load_i      (hu.ex_mem_to_reg),
      .mem_rd_i       (hu.mem_rd),
      .mem_load_i     (hu.mem_mem_to_reg),
      .ex_conflict_o  (ex_conf),
      .mem_conflict_o (mem_conf)
   );

   always_comb begin
      is_mem = hu.mem_dren | hu.mem_dwen;
      // Once frozen, only dhit releases the pipeline.
      wait_c = (state_q == MEM_WAIT) ? ~hu.dhit : (is_mem & ~hu.dhit);
      // Leaving MEM_WAIT resumes whatever was interrupted in the same cycle.
      eff_state = state_q;
      if (state_q == MEM_WAIT)
         eff_state = (bcnt_q != 2'd0) ? LOAD_STALL : RUN;
      state_d = eff_state;
      bcnt_d  = bcnt_q;
      halt_d  = halt_q;
      flush   = '0;
      en      = '1;
      if (state_q == HALTED) begin
         state_d   = HALTED;
         en        = '0;
         flush.mwb = 1'b1;
      end else if (wait_c) begin
         state_d = MEM_WAIT;
         en      = '0;
      end else if (hu.mem_halt) begin
         state_d   = HALTED;
         halt_d    = 1'b1;
         en        = '0;
         flush.mwb = 1'b1;
      end else if (hu.mem_branch_taken) begin
         flush.fd = 1'b1;
         flush.de = 1'b1;
         flush.em = 1'b1;
         if (!hu.ihit) begin
            en.fd = 1'b0;
            en.de = 1'b0;
         end
         state_d = RUN;
         bcnt_d  = 2'd0;
      end else if (eff_state == LOAD_STALL) begin
         en.fd    = 1'b0;
         flush.de = 1'b1;
         bcnt_d   = bcnt_q - 2'd1;
         state_d  = (bcnt_q == 2'd1) ? RUN : LOAD_STALL;
      end else if (ex_conf) begin
         en.fd    = 1'b0;
         flush.de = 1'b1;
         bcnt_d   = LS_INIT;
         state_d  = (LS_INIT != 2'd0) ? LOAD_STALL : RUN;
      end else if (hu.id_jump && hu.ihit) begin
         flush.fd = 1'b1;
      end else if (!hu.ihit) begin
         en.fd    = 1'b0;
         flush.de = 1'b1;
      end
      if (RST) begin
         flush = '1;
         en    = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         bcnt_q  <= 2'd0;
         halt_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         halt_q  <= halt_d;
         if (!en.fd)
            stall_q <= stall_q + 1'b1;
      end
   end

   assign hu.hu_fetch_decode_flush       = flush.fd;
   assign hu.hu_fetch_decode_enable      = en.fd;
   assign hu.hu_decode_execute_flush     = flush.de;
   assign hu.hu_decode_execute_enable    = en.de;
   assign hu.hu_execute_memory_flush     = flush.em;
   assign hu.hu_execute_memory_enable    = en.em;
   assign hu.hu_memory_write_back_flush  = flush.mwb;
   assign hu.hu_memory_write_back_enable = en.mwb;
   assign hu.hu_decode_execute_conflict  = ex_conf;
   assign hu.hu_decode_memory_conflict   = mem_conf;
   assign hu.hu_is_mem                   = is_mem;
   assign hu.halt                        = halt_q;
   assign hu.stall_cycles                = stall_q;

endmodule
